// File: rtl/pkt_rd_sched.sv
// pkt_rd_sched: picks one queued packet at a time from NPORT ingress buffers
// (highest priority first, round-robin among equals). It then reads that
// buffer for exactly the packet length and forwards the bytes with
// sop/eop/vld framing.
//
// Handshake semantics:
//   info_vld is a one-cycle strobe with no back-pressure. info_full is
//   advisory only; a word that arrives at a full queue, with no pop on that
//   port in the same cycle, is dropped and flagged in sticky info_ovf.
//   data_ren/out_rdy: a read is issued only in a cycle where out_rdy is high.
//   The byte appears on out_data one cycle later, qualified by out_vld, and
//   the downstream must take it. No more than one byte is ever in flight.
module pkt_rd_sched #(
  parameter int NPORT      = 4,
  parameter int INFO_DEPTH = 8,
  parameter int PW         = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NPORT*20-1:0] info_in,
  input  logic [NPORT-1:0]    info_vld,
  output logic [NPORT-1:0]    info_full,
  output logic [NPORT-1:0]    info_ovf,
  output logic [NPORT-1:0]    data_ren,
  input  logic [NPORT*8-1:0]  data_in,
  input  logic                out_rdy,
  output logic                out_vld,
  output logic                out_sop,
  output logic                out_eop,
  output logic [7:0]          out_data,
  output logic [19:0]         out_info,
  output logic [PW-1:0]       out_port,
  output logic                busy,
  output logic [1:0]          fsm_state
);

  localparam int AW = $clog2(INFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t state;

  // Per-port info queues
  logic [19:0]    mem    [NPORT][INFO_DEPTH];
  logic [AW-1:0]  wr_ptr [NPORT];
  logic [AW-1:0]  rd_ptr [NPORT];
  logic [CW-1:0]  cnt    [NPORT];
  logic [CW-1:0]  cnt_nxt[NPORT];
  logic [19:0]    head   [NPORT];
  logic [NPORT-1:0] nonempty;
  logic [NPORT-1:0] push;
  logic [NPORT-1:0] pop;
  logic             any_next;

  // Scheduler state
  logic [PW-1:0] grant;
  logic [PW-1:0] last_grant;
  logic [PW-1:0] win;
  logic          win_vld;
  logic [3:0]    win_pri;
  logic [12:0]   remain;
  logic          first;
  logic          ren_any;

  // Queue heads and occupancy flags, straight from registered state
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      nonempty[i] = (cnt[i] != '0);
      head[i]     = mem[i][rd_ptr[i]];
    end
  end

  // Pick the highest-priority non-empty head, scanning from the port after
  // last_grant so that the first port found wins ties
  always_comb begin : arb_c
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    win_pri = '0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = (int'(last_grant) + k) % NPORT;
      if (nonempty[idx] && (!win_vld || (head[idx][7:4] > win_pri))) begin
        win_vld = 1'b1;
        win     = PW'(idx);
        win_pri = head[idx][7:4];
      end
    end
    pop = '0;
    if ((state == ARB) && win_vld) pop[win] = 1'b1;
  end

  // Push acceptance and next occupancy; a full queue still accepts a word
  // when its head is popped in the same cycle
  always_comb begin
    any_next = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      push[i]    = info_vld[i] && ((cnt[i] != CW'(INFO_DEPTH)) || pop[i]);
      cnt_nxt[i] = cnt[i] + CW'(push[i]) - CW'(pop[i]);
      if (cnt_nxt[i] != '0) any_next = 1'b1;
    end
  end

  // Queue storage (no reset needed, occupancy is tracked by cnt)
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NPORT; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= info_in[20*i +: 20];
    end
  end

  // Queue pointers, counts, full and sticky overflow flags
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NPORT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      info_full <= '0;
      info_ovf  <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        cnt[i]       <= cnt_nxt[i];
        info_full[i] <= (cnt_nxt[i] == CW'(INFO_DEPTH));
        if (info_vld[i] && !push[i]) info_ovf[i] <= 1'b1;
      end
    end
  end

  // A read is issued whenever a packet still has bytes left and downstream is ready
  assign ren_any = (state == XFER) && (remain != '0) && out_rdy;

  // One-hot read enable toward the granted ingress FIFO
  always_comb begin
    data_ren = '0;
    if (ren_any) data_ren[grant] = 1'b1;
  end

  // The FIFO dout carries the byte read in the previous cycle
  assign out_data  = out_vld ? data_in[int'(grant)*8 +: 8] : 8'h00;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Scheduler FSM: arbitration, length tracking and output framing
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= PW'(NPORT - 1);
      remain     <= '0;
      first      <= 1'b0;
      out_info   <= '0;
      out_port   <= '0;
      out_vld    <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
    end else begin
      out_vld <= ren_any;
      out_sop <= ren_any && first;
      out_eop <= ren_any && (remain == 13'd1);
      case (state)
        IDLE: begin
          if (|nonempty) state <= ARB;
        end
        ARB: begin
          if (win_vld) begin
            grant    <= win;
            out_port <= win;
            out_info <= head[win];
            // A zero length field stands for 4096 bytes (12-bit wrap upstream)
            remain   <= (head[win][19:8] == 12'd0) ? 13'd4096 : {1'b0, head[win][19:8]};
            first    <= 1'b1;
            state    <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (ren_any) begin
            remain <= remain - 13'd1;
            first  <= 1'b0;
            if (remain == 13'd1) begin
              last_grant <= grant;
              state      <= any_next ? ARB : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
